// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/MOSI/CS_N in the clk domain, deserialises MOSI
// into bytes and serialises a one-entry buffered response byte onto MISO.
module spi_slave #(
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS_N,
  output logic       MISO,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_pending,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sck_prev_q, csn_prev_q;
  logic [7:0]             rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [7:0]             tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic [2:0]             rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic                   rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic                   pend_q, pend_d, miso_q, miso_d;
  logic                   sclk_s, mosi_s, csn_s, sck;
  logic                   lead, trail, sample_e, shift_e, cs_fall, cs_rise, consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], CS_N};
      sck_prev_q  <= sck;
      csn_prev_q  <= csn_s;
    end
  end

  // Normalising by CPOL makes "leading edge" always a 0->1 transition of sck.
  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign sck      = sclk_s ^ CPOL;
  assign lead     = sck & ~sck_prev_q;
  assign trail    = ~sck & sck_prev_q;
  assign sample_e = CPHA ? trail : lead;
  assign shift_e  = CPHA ? lead : trail;
  assign cs_fall  = csn_prev_q & ~csn_s;
  assign cs_rise  = ~csn_prev_q & csn_s;

  always_comb begin
    state_d    = state_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_cnt_d   = rx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = ACTIVE;
          rx_cnt_d = 3'd0;
          tx_cnt_d = 3'd0;
          miso_d   = 1'b0;
          consume  = 1'b1;
        end
      end
      ACTIVE: begin
        if (sample_e) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          rx_cnt_d   = rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end
        if (shift_e && !cs_rise) begin
          if (CPHA) miso_d = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          tx_cnt_d   = tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd7) consume = 1'b1;
        end
        // A byte completing on the same cycle still reports before we drop out.
        if (cs_rise) begin
          state_d  = IDLE;
          rx_cnt_d = 3'd0;
          tx_cnt_d = 3'd0;
          miso_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (consume) begin
      if (pend_q) begin
        tx_shift_d = hold_q;
        pend_d     = 1'b0;
      end else begin
        tx_shift_d = 8'hFF;
        underrun_d = 1'b1;
      end
    end
    // A load on a consume cycle lands after the consume: old byte goes out, new one waits.
    if (tx_load) begin
      hold_d = tx_data;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign MISO        = CPHA ? miso_q : (busy & tx_shift_q[7]);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_pending  = pend_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Drives one slave per CPOL/CPHA mode from a behavioural SPI master; a queue-based
// model of the holding buffer predicts MISO bytes, rx bytes and underrun counts.
module tb_spi_slave;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      sclk, mosi, cs_n, tx_load;
  logic [3:0][7:0] tx_data;
  wire  [3:0]      miso_w, rx_valid_w, tx_pending_w, tx_underrun_w, busy_w;
  wire  [3:0][7:0] rx_data_w;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rx   [4][$];
  logic [7:0] exp_miso [4][$];
  int   under_cnt [4] = '{0, 0, 0, 0};
  int   under_exp [4] = '{0, 0, 0, 0};
  logic pend_m    [4] = '{0, 0, 0, 0};
  logic [7:0] hold_m [4];

  logic [7:0] mbuf   [8];
  logic       ld_en  [8];
  logic [7:0] ld_val [8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gm
    spi_slave #(.CPOL((g / 2) != 0), .CPHA((g % 2) != 0), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .SCLK(sclk[g]), .MOSI(mosi[g]), .CS_N(cs_n[g]),
      .MISO(miso_w[g]), .rx_data(rx_data_w[g]), .rx_valid(rx_valid_w[g]),
      .tx_data(tx_data[g]), .tx_load(tx_load[g]), .tx_pending(tx_pending_w[g]),
      .tx_underrun(tx_underrun_w[g]), .busy(busy_w[g])
    );

    logic [7:0] e;
    always @(negedge clk) begin
      if (rx_valid_w[g]) begin
        if (exp_rx[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m%0d_rx_unexpected got=%0h exp=none", g, rx_data_w[g]);
        end else begin
          e = exp_rx[g].pop_front();
          check($sformatf("m%0d_rx_data", g), rx_data_w[g], e);
        end
      end
      if (tx_underrun_w[g]) under_cnt[g]++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_consume(input int m);
    if (pend_m[m]) begin
      exp_miso[m].push_back(hold_m[m]);
      pend_m[m] = 1'b0;
    end else begin
      exp_miso[m].push_back(8'hFF);
      under_exp[m]++;
    end
  endtask

  task automatic load(input int m, input logic [7:0] v);
    tx_data[m] = v;
    tx_load[m] = 1'b1;
    clks(1);
    tx_load[m] = 1'b0;
    pend_m[m]  = 1'b1;
    hold_m[m]  = v;
  endtask

  // cut = bits sent in the last byte; special_k = byte whose final shift edge coincides with a load.
  task automatic xfer(input int m, input int nbytes, input int cut, input int special_k, input bit do_rst);
    logic cpol, cpha;
    logic [7:0] got, e;
    int nb;
    cpol = (m >= 2);
    cpha = (m % 2) == 1;
    cs_n[m] = 1'b0;
    m_consume(m);
    clks(H);
    check($sformatf("m%0d_busy_on", m), busy_w[m], 1);
    check($sformatf("m%0d_pend_entry", m), tx_pending_w[m], pend_m[m]);
    for (int k = 0; k < nbytes; k++) begin
      nb  = (k == nbytes - 1) ? cut : 8;
      if (nb == 8) exp_rx[m].push_back(mbuf[k]);
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          mosi[m] = mbuf[k][7-i];
          clks(H);
          got = {got[6:0], miso_w[m]};
          sclk[m] = ~cpol;
          clks(H);
          sclk[m] = cpol;
        end else begin
          sclk[m] = ~cpol;
          mosi[m] = mbuf[k][7-i];
        end
        if (i == 7) begin
          m_consume(m);
          if (k == special_k) begin
            clks(2);
            load(m, ld_val[k]);
          end
        end
        if (cpha) begin
          clks(H);
          got = {got[6:0], miso_w[m]};
          sclk[m] = cpol;
          clks(H);
        end
        if (i == 0 && ld_en[k]) load(m, ld_val[k]);
      end
      if (nb == 8) begin
        e = exp_miso[m].pop_front();
        check($sformatf("m%0d_miso_byte%0d", m, k), got, e);
      end
    end
    if (do_rst) begin
      rst = 1'b1;
      clks(2);
      check($sformatf("m%0d_rst_miso", m), miso_w[m], 0);
      check($sformatf("m%0d_rst_busy", m), busy_w[m], 0);
      check($sformatf("m%0d_rst_pend", m), tx_pending_w[m], 0);
      check($sformatf("m%0d_rst_rxdata", m), rx_data_w[m], 0);
      check($sformatf("m%0d_rst_rxvalid", m), rx_valid_w[m], 0);
      cs_n[m] = 1'b1;
      sclk[m] = cpol;
      mosi[m] = 1'b0;
      clks(1);
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
        pend_m[j] = 1'b0;
        exp_rx[j].delete();
        exp_miso[j].delete();
      end
      clks(4);
    end else begin
      clks(H);
      cs_n[m] = 1'b1;
      mosi[m] = 1'b0;
      clks(H);
      check($sformatf("m%0d_busy_off", m), busy_w[m], 0);
      check($sformatf("m%0d_miso_idle", m), miso_w[m], 0);
      check($sformatf("m%0d_pend_after", m), tx_pending_w[m], pend_m[m]);
      check($sformatf("m%0d_rx_all_seen", m), exp_rx[m].size(), 0);
      check($sformatf("m%0d_underruns", m), under_cnt[m], under_exp[m]);
      exp_miso[m].delete();
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) begin
      ld_en[i]  = 1'b0;
      ld_val[i] = 8'h00;
      mbuf[i]   = 8'h00;
    end
  endtask

  initial begin
    int m, nbytes;
    sclk    = 4'b1100;
    cs_n    = 4'b1111;
    mosi    = 4'b0000;
    tx_load = 4'b0000;
    tx_data = '0;
    clear_plan();
    clks(3);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("m%0d_reset_outs", j),
            {miso_w[j], rx_valid_w[j], tx_pending_w[j], tx_underrun_w[j], busy_w[j], rx_data_w[j]}, 0);
    end
    rst = 1'b0;
    clks(4);

    // Preloaded single byte, mode 0.
    load(0, 8'h3C);
    check("m0_pend_preload", tx_pending_w[0], 1);
    mbuf[0] = 8'hA5;
    xfer(0, 1, 8, -1, 1'b0);

    // Three-byte bursts in every mode, refilled once per byte.
    for (int j = 0; j < 4; j++) begin
      clear_plan();
      mbuf[0] = 8'h01; mbuf[1] = 8'h80; mbuf[2] = 8'hFF;
      ld_en[0] = 1'b1; ld_val[0] = 8'h22;
      ld_en[1] = 1'b1; ld_val[1] = 8'h33;
      ld_en[2] = 1'b1; ld_val[2] = 8'h44;
      load(j, 8'h11);
      xfer(j, 3, 8, -1, 1'b0);
    end

    // No preload: 0xFF goes out with an underrun.
    clear_plan();
    mbuf[0] = 8'h5A;
    xfer(0, 1, 8, -1, 1'b0);

    // Chip select dropped after 5 bits, then a clean byte.
    clear_plan();
    mbuf[0] = 8'hE7;
    xfer(1, 1, 5, -1, 1'b0);
    mbuf[0] = 8'hC3;
    xfer(1, 1, 8, -1, 1'b0);

    // Load landing exactly on the byte-boundary consume with nothing pending.
    clear_plan();
    mbuf[0] = 8'h12; mbuf[1] = 8'h34; mbuf[2] = 8'h56;
    ld_val[0] = 8'h77;
    load(0, 8'h3C);
    xfer(0, 3, 8, 0, 1'b0);

    // Reset mid-byte with a byte pending, then a normal transfer.
    clear_plan();
    mbuf[0] = 8'hF0;
    ld_en[0] = 1'b1; ld_val[0] = 8'h34;
    load(0, 8'h12);
    xfer(0, 1, 4, -1, 1'b1);
    clear_plan();
    mbuf[0] = 8'h96;
    load(0, 8'h69);
    xfer(0, 1, 8, -1, 1'b0);

    // Randomised transfers across modes.
    for (int r = 0; r < 12; r++) begin
      clear_plan();
      m      = $urandom_range(0, 3);
      nbytes = $urandom_range(1, 3);
      for (int k = 0; k < nbytes; k++) begin
        mbuf[k]   = 8'($urandom);
        ld_en[k]  = 1'($urandom);
        ld_val[k] = 8'($urandom);
      end
      if (1'($urandom)) load(m, 8'($urandom));
      xfer(m, nbytes, 8, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
